// File: rtl/pipe_ctrl_bubble_pipe.sv
// Control-word pipeline from ID through STAGES registers, with zero-control bubble
// injection on kill/flush/stall/invalid, a multi-cycle flush counter and a bubble counter.
module pipe_ctrl_bubble_pipe #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned STAGES = 3,
  parameter int unsigned FLEN_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     ctrl_vld,
  input  logic                     stall,
  input  logic                     flush_req,
  input  logic [FLEN_W-1:0]        flush_len,
  input  logic [STAGES-1:0]        kill_mask,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        vld_out,
  output logic                     flush_busy,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic [CTRL_W-1:0] stage_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [FLEN_W-1:0] fcnt_q;
  logic [FLEN_W-1:0] fcnt_dec;
  logic [FLEN_W-1:0] fcnt_nxt;
  logic              busy_q;
  logic [CNT_W-1:0]  bcnt_q;
  logic              s0_bubble;

  always_comb begin
    fcnt_dec = (fcnt_q == '0) ? '0 : fcnt_q - FLEN_W'(1);
    fcnt_nxt = fcnt_dec;
    // A new request never shortens a flush already in progress.
    if (flush_req && (flush_len > fcnt_dec))
      fcnt_nxt = flush_len;
    s0_bubble = kill_mask[0] | flush_req | (fcnt_q != '0) | stall | ~ctrl_vld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++)
        stage_q[k] <= '0;
      vld_q  <= '0;
      fcnt_q <= '0;
      busy_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      if (s0_bubble) begin
        stage_q[0] <= '0;
        vld_q[0]   <= 1'b0;
      end else begin
        stage_q[0] <= ctrl_in;
        vld_q[0]   <= 1'b1;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (kill_mask[k]) begin
          stage_q[k] <= '0;
          vld_q[k]   <= 1'b0;
        end else begin
          stage_q[k] <= stage_q[k-1];
          vld_q[k]   <= vld_q[k-1];
        end
      end
      fcnt_q <= fcnt_nxt;
      busy_q <= (fcnt_nxt != '0);
      if (s0_bubble && (bcnt_q != '1))
        bcnt_q <= bcnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int unsigned k = 0; k < STAGES; k++)
      ctrl_out[k*CTRL_W +: CTRL_W] = stage_q[k];
  end

  assign vld_out    = vld_q;
  assign flush_busy = busy_q;
  assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_pipe_ctrl_bubble_pipe.sv
// Directed bench for pipe_ctrl_bubble_pipe: per-edge vector table plus hand sequences
// for async reset mid-flush and bubble-counter saturation (narrow-counter instance).
module tb_pipe_ctrl_bubble_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ctrl_in;
  logic        ctrl_vld, stall, flush_req;
  logic [2:0]  flush_len, kill_mask;
  logic [29:0] ctrl_out;
  logic [2:0]  vld_out;
  logic        flush_busy;
  logic [15:0] bubble_cnt;

  logic [29:0] sat_ctrl_out;
  logic [2:0]  sat_vld_out;
  logic        sat_busy;
  logic [3:0]  sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_bubble_pipe #(.CTRL_W(10), .STAGES(3), .FLEN_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .ctrl_vld(ctrl_vld), .stall(stall),
    .flush_req(flush_req), .flush_len(flush_len), .kill_mask(kill_mask),
    .ctrl_out(ctrl_out), .vld_out(vld_out), .flush_busy(flush_busy), .bubble_cnt(bubble_cnt)
  );

  // Idle-input instance with a 4-bit counter: every edge is a bubble, so it saturates fast.
  pipe_ctrl_bubble_pipe #(.CTRL_W(10), .STAGES(3), .FLEN_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ctrl_in(10'h0), .ctrl_vld(1'b0), .stall(1'b0),
    .flush_req(1'b0), .flush_len(3'd0), .kill_mask(3'b000),
    .ctrl_out(sat_ctrl_out), .vld_out(sat_vld_out), .flush_busy(sat_busy), .bubble_cnt(sat_cnt)
  );

  typedef struct {
    logic [9:0]  ci;
    logic        v, st, fr;
    logic [2:0]  fl, km;
    logic [29:0] eo;
    logic [2:0]  ev;
    logic        eb;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  localparam logic [9:0] A = 10'h2A5, B = 10'h111, C = 10'h0F0, D = 10'h3C3;
  localparam logic [9:0] E = 10'h155, F = 10'h0AA, G = 10'h333, H = 10'h1E1;

  function automatic logic [29:0] pk(logic [9:0] s2, logic [9:0] s1, logic [9:0] s0);
    return {s2, s1, s0};
  endfunction

  function automatic void add(logic [9:0] ci, logic v, logic st, logic fr, logic [2:0] fl,
                              logic [2:0] km, logic [29:0] eo, logic [2:0] ev, logic eb,
                              logic [15:0] ec);
    vec_t t;
    t.ci = ci; t.v = v; t.st = st; t.fr = fr; t.fl = fl; t.km = km;
    t.eo = eo; t.ev = ev; t.eb = eb; t.ec = ec;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [29:0] eo, logic [2:0] ev, logic eb, logic [15:0] ec);
    chk({tag, " ctrl_out"}, 32'(ctrl_out), 32'(eo));
    chk({tag, " vld_out"}, 32'(vld_out), 32'(ev));
    chk({tag, " flush_busy"}, 32'(flush_busy), 32'(eb));
    chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(ec));
  endtask

  task automatic drive(logic [9:0] ci, logic v, logic st, logic fr, logic [2:0] fl, logic [2:0] km);
    ctrl_in = ci; ctrl_vld = v; stall = st; flush_req = fr; flush_len = fl; kill_mask = km;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   ci v st fr fl   km       expected {s2,s1,s0}  vld    busy cnt
    add(A, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, A), 3'b001, 0, 0);   // single instr walks down
    add(0, 0, 0, 0, 3'd0, 3'b000, pk(0, A, 0), 3'b010, 0, 1);
    add(0, 0, 0, 0, 3'd0, 3'b000, pk(A, 0, 0), 3'b100, 0, 2);
    add(B, 1, 0, 1, 3'd2, 3'b000, pk(0, 0, 0), 3'b000, 1, 3);   // flush len 2
    add(C, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, 0), 3'b000, 1, 4);
    add(D, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, 0), 3'b000, 0, 5);
    add(E, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, E), 3'b001, 0, 5);
    add(F, 1, 0, 1, 3'd3, 3'b000, pk(0, E, 0), 3'b010, 1, 6);   // len 3 then len 1
    add(G, 1, 0, 1, 3'd1, 3'b000, pk(E, 0, 0), 3'b100, 1, 7);
    add(H, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, 0), 3'b000, 1, 8);
    add(H, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, 0), 3'b000, 0, 9);
    add(A, 1, 0, 0, 3'd0, 3'b000, pk(0, 0, A), 3'b001, 0, 9);
    add(B, 1, 1, 0, 3'd0, 3'b000, pk(0, A, 0), 3'b010, 0, 10);  // stall
    add(B, 1, 0, 0, 3'd0, 3'b000, pk(A, 0, B), 3'b101, 0, 10);
    add(C, 1, 0, 0, 3'd0, 3'b000, pk(0, B, C), 3'b011, 0, 10);
    add(D, 1, 0, 0, 3'd0, 3'b010, pk(B, 0, D), 3'b101, 0, 10);  // kill stage 1
    add(E, 1, 0, 0, 3'd0, 3'b001, pk(0, D, 0), 3'b010, 0, 11);  // kill beats real input
    add(F, 1, 1, 1, 3'd0, 3'b111, pk(0, 0, 0), 3'b000, 0, 12);  // all causes: one bubble
    add(G, 1, 0, 0, 3'd0, 3'b100, pk(0, 0, G), 3'b001, 0, 12);  // kill on a bubble
    add(H, 1, 0, 1, 3'd2, 3'b000, pk(0, G, 0), 3'b010, 1, 13);
    add(A, 1, 0, 0, 3'd0, 3'b000, pk(G, 0, 0), 3'b100, 1, 14);

    drive(0, 0, 0, 0, 3'd0, 3'b000);
    reset = 1'b1;
    #12;
    chk_all("reset", pk(0, 0, 0), 3'b000, 0, 0);
    chk("reset sat_cnt", 32'(sat_cnt), 32'd0);
    #8 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ci, vecs[i].v, vecs[i].st, vecs[i].fr, vecs[i].fl, vecs[i].km);
      step();
      chk_all($sformatf("vec%0d", i + 1), vecs[i].eo, vecs[i].ev, vecs[i].eb, vecs[i].ec);
    end

    // Fill all stages, start a flush, then reset asynchronously mid-cycle.
    drive(A, 1, 0, 0, 3'd0, 3'b000); step();
    chk_all("drain", pk(0, 0, 0), 3'b000, 0, 15);
    drive(B, 1, 0, 0, 3'd0, 3'b000); step();
    drive(C, 1, 0, 0, 3'd0, 3'b000); step();
    drive(D, 1, 0, 0, 3'd0, 3'b000); step();
    chk_all("full", pk(B, C, D), 3'b111, 0, 15);
    drive(E, 1, 0, 1, 3'd2, 3'b000); step();
    chk_all("preflush", pk(C, D, 0), 3'b110, 1, 16);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", pk(0, 0, 0), 3'b000, 0, 0);
    #3 reset = 1'b0;
    drive(F, 1, 0, 0, 3'd0, 3'b000); step();
    chk_all("post_reset", pk(0, 0, F), 3'b001, 0, 0);
    chk("sat_cnt 1", 32'(sat_cnt), 32'd1);

    drive(0, 0, 0, 0, 3'd0, 3'b000);
    repeat (13) step();
    chk("sat_cnt 14", 32'(sat_cnt), 32'd14);
    chk("bubble_cnt 13", 32'(bubble_cnt), 32'd13);
    step();
    chk("sat_cnt full", 32'(sat_cnt), 32'd15);
    repeat (5) step();
    chk("sat_cnt hold", 32'(sat_cnt), 32'd15);
    chk("bubble_cnt 19", 32'(bubble_cnt), 32'd19);
    chk("sat vld idle", 32'(sat_vld_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got time %0t expected < 20000", $time);
    $fatal(1);
  end

endmodule
